// File: rtl/test_value_display.sv
// test_value_display: samples the 16-bit datapath test word and scans it as hex
// on a common-anode, time-multiplexed 7-segment display (active-low an/seg/dp).
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading-zero digits k>=1).
module test_value_display #(
  parameter int DIGITS      = 4,
  parameter int DATA_WIDTH  = 16,      // must equal 4*DIGITS
  parameter int REFRESH_DIV = 100000   // cycles each digit stays lit, >= 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] test_value,
  input  logic                  freeze,
  output logic                  changed,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] value_q;

  logic [3:0]            nib;
  logic [DIGITS-1:0]     an_next;
  logic                  blank;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Refresh divider and digit index; the scan free-runs regardless of freeze.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Sample register; changed flags a load that alters the held value.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
      changed <= 1'b0;
    end else if (!freeze) begin
      value_q <= test_value;
      changed <= (test_value != value_q);
    end else begin
      changed <= 1'b0;
    end
  end

  // Select the current digit's nibble and build the one-hot-low enable.
  always_comb begin
    nib     = 4'h0;
    an_next = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        nib        = value_q[4*k +: 4];
        an_next[k] = 1'b0;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_vec;

  // A digit k>=1 is blank while it and every more-significant nibble are zero.
  always_comb begin
    logic hi_zero;
    hi_zero   = 1'b1;
    blank_vec = '0;
    blank     = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      hi_zero      = hi_zero & (value_q[4*k +: 4] == 4'h0);
      blank_vec[k] = hi_zero;
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) blank = blank_vec[k];
    end
  end
`else
  // Every digit always lit; leading zeros display as "0".
  always_comb begin
    blank = 1'b0;
  end
`endif

  // Registered pins: display dark in reset, otherwise show the selected digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= '1;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= blank ? '1 : an_next;
      seg <= blank ? 7'b1111111 : hex7(nib);
      dp  <= !((idx == '0) && freeze);
    end
  end

endmodule
